// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer. It allocates one tag per decoded instruction
// and captures CDB results. It answers dispatch operand lookups by tag, retires
// at most one entry per cycle in program order, and flushes the whole buffer
// when a mispredicted control instruction retires.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_reg_dest,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic             cdb_mispredict,
  input  logic [31:0]      cdb_target,
  input  logic [TAG_W-1:0] q1_tag,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q1_ready,
  output logic [31:0]      q1_data,
  output logic             q2_ready,
  output logic [31:0]      q2_data,
  output logic             commit_valid,
  output logic [4:0]       commit_reg_dest,
  output logic [TAG_W-1:0] commit_tag,
  output logic [31:0]      commit_data,
  output logic             clear,
  output logic [31:0]      clear_pc
);

  // Per-entry control flags (reset) and payload (not reset).
  logic [ROB_SIZE-1:0] busy;
  logic [ROB_SIZE-1:0] ready;
  logic [ROB_SIZE-1:0] mispredict;
  logic [4:0]          reg_dest_q [ROB_SIZE];
  logic [31:0]         data_q     [ROB_SIZE];
  logic [31:0]         target_q   [ROB_SIZE];

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;

  logic do_alloc;
  logic do_write;
  logic do_commit;
  logic do_flush;

  assign full      = (count == (TAG_W+1)'(ROB_SIZE));
  assign alloc_tag = tail;

  // All events are suppressed while the flush pulse is out; full is the
  // pre-edge value, so an allocate alongside a commit while full is dropped.
  assign do_alloc  = alloc_valid && !full && !clear;
  assign do_write  = cdb_valid && busy[cdb_tag] && !clear;
  assign do_commit = busy[head] && ready[head] && !clear;
  assign do_flush  = do_commit && mispredict[head];

  // Operand lookups with same-cycle CDB bypass.
  always_comb begin
    q1_ready = ready[q1_tag];
    q1_data  = data_q[q1_tag];
    q2_ready = ready[q2_tag];
    q2_data  = data_q[q2_tag];
    if (cdb_valid && (cdb_tag == q1_tag)) begin
      q1_ready = 1'b1;
      q1_data  = cdb_data;
    end
    if (cdb_valid && (cdb_tag == q2_tag)) begin
      q2_ready = 1'b1;
      q2_data  = cdb_data;
    end
  end

  // Pointers, entry flags, commit port and flush pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      busy            <= '0;
      ready           <= '0;
      mispredict      <= '0;
      commit_valid    <= 1'b0;
      commit_reg_dest <= '0;
      commit_tag      <= '0;
      commit_data     <= '0;
      clear           <= 1'b0;
      clear_pc        <= '0;
    end else if (rdy) begin
      commit_valid <= do_commit;
      clear        <= do_flush;

      if (do_commit) begin
        commit_reg_dest <= reg_dest_q[head];
        commit_tag      <= head;
        commit_data     <= data_q[head];
      end
      if (do_flush) begin
        clear_pc <= target_q[head];
      end

      // The allocated slot is never busy when allocation is allowed, so the
      // allocate and CDB updates below never target the same entry.
      if (do_alloc) begin
        busy[tail]       <= 1'b1;
        ready[tail]      <= 1'b0;
        mispredict[tail] <= 1'b0;
        tail             <= tail + 1'b1;
      end
      if (do_write) begin
        ready[cdb_tag]      <= 1'b1;
        mispredict[cdb_tag] <= cdb_mispredict;
      end
      if (do_commit) begin
        busy[head] <= 1'b0;
        head       <= head + 1'b1;
      end

      case ({do_alloc, do_commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // NOTE: within one always_ff the last non-blocking assignment to a
      // variable wins, so the flush overrides the individual updates above.
      if (do_flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
      end
    end
  end

  // Entry payload storage.
  // NOTE: payload arrays have no reset; every read of them is qualified by a
  // flag that is reset, so the reset fan-out stays on the flags only.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (do_alloc) begin
        reg_dest_q[tail] <= alloc_reg_dest;
      end
      if (do_write) begin
        data_q[cdb_tag]   <= cdb_data;
        target_q[cdb_tag] <= cdb_target;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer. A queue-based program-order model
// predicts every output each cycle. Directed scenarios add explicit constant
// checks, and a randomized phase follows.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        alloc_valid;
  logic [4:0]  alloc_reg_dest;
  logic [3:0]  alloc_tag;
  logic        full;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_mispredict;
  logic [31:0] cdb_target;
  logic [3:0]  q1_tag, q2_tag;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_data, q2_data;
  logic        commit_valid;
  logic [4:0]  commit_reg_dest;
  logic [3:0]  commit_tag;
  logic [31:0] commit_data;
  logic        clear;
  logic [31:0] clear_pc;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_SIZE(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_reg_dest(alloc_reg_dest),
    .alloc_tag(alloc_tag), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .q1_tag(q1_tag), .q2_tag(q2_tag),
    .q1_ready(q1_ready), .q1_data(q1_data),
    .q2_ready(q2_ready), .q2_data(q2_data),
    .commit_valid(commit_valid), .commit_reg_dest(commit_reg_dest),
    .commit_tag(commit_tag), .commit_data(commit_data),
    .clear(clear), .clear_pc(clear_pc)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: in-flight instructions in program order plus per-tag results.
  typedef struct packed {
    logic [3:0] tag;
    logic [4:0] dest;
  } ent_t;

  ent_t        mq[$];
  int          m_tail = 0;
  bit          m_ready [16];
  logic [31:0] m_data  [16];
  bit          m_mp    [16];
  logic [31:0] m_tgt   [16];
  bit          e_cv, e_clear;
  logic [4:0]  e_cdest;
  logic [3:0]  e_ctag;
  logic [31:0] e_cdata, e_cpc;

  function automatic bit in_flight(input logic [3:0] t);
    foreach (mq[i]) if (mq[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    if (rst) begin
      mq.delete();
      m_tail = 0;
      for (int i = 0; i < 16; i++) m_ready[i] = 1'b0;
      e_cv = 0; e_cdest = 0; e_ctag = 0; e_cdata = 0; e_clear = 0; e_cpc = 0;
    end else if (rdy) begin
      bit   a, w, c, fl;
      ent_t hd;
      a  = alloc_valid && (mq.size() < 16) && !e_clear;
      w  = cdb_valid && in_flight(cdb_tag) && !e_clear;
      c  = (mq.size() > 0) && m_ready[mq[0].tag] && !e_clear;
      fl = 1'b0;
      e_cv = c;
      if (c) begin
        hd      = mq.pop_front();
        fl      = m_mp[hd.tag];
        e_cdest = hd.dest;
        e_ctag  = hd.tag;
        e_cdata = m_data[hd.tag];
        if (fl) e_cpc = m_tgt[hd.tag];
      end
      e_clear = fl;
      if (w) begin
        m_ready[cdb_tag] = 1'b1;
        m_data[cdb_tag]  = cdb_data;
        m_mp[cdb_tag]    = cdb_mispredict;
        m_tgt[cdb_tag]   = cdb_target;
      end
      if (a) begin
        mq.push_back('{tag: 4'(m_tail), dest: alloc_reg_dest});
        m_ready[m_tail] = 1'b0;
        m_mp[m_tail]    = 1'b0;
        m_tail          = (m_tail + 1) % 16;
      end
      if (fl) begin
        mq.delete();
        m_tail = 0;
      end
    end
  endtask

  task automatic lookup(input logic [3:0] t, output bit r, output logic [31:0] d);
    if (cdb_valid && cdb_tag == t) begin
      r = 1'b1; d = cdb_data;
    end else begin
      r = m_ready[t]; d = m_data[t];
    end
  endtask

  // One clock: check combinational outputs, advance model, check registers.
  task automatic cyc(input bit chk_comb = 1'b1);
    bit          er;
    logic [31:0] ed;
    #1;
    if (chk_comb) begin
      check("alloc_tag", 32'(alloc_tag), 32'(m_tail));
      check("full", 32'(full), 32'(mq.size() == 16));
      lookup(q1_tag, er, ed);
      check("q1_ready", 32'(q1_ready), 32'(er));
      if (er) check("q1_data", q1_data, ed);
      lookup(q2_tag, er, ed);
      check("q2_ready", 32'(q2_ready), 32'(er));
      if (er) check("q2_data", q2_data, ed);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("commit_valid", 32'(commit_valid), 32'(e_cv));
    check("clear", 32'(clear), 32'(e_clear));
    check("clear_pc", clear_pc, e_cpc);
    if (e_cv) begin
      check("commit_reg_dest", 32'(commit_reg_dest), 32'(e_cdest));
      check("commit_tag", 32'(commit_tag), 32'(e_ctag));
      check("commit_data", commit_data, e_cdata);
    end
  endtask

  task automatic drive(input bit av, input logic [4:0] d, input bit cv,
                       input logic [3:0] t, input logic [31:0] dat,
                       input bit mp = 1'b0, input logic [31:0] tg = 32'h0);
    rst = 1'b0; rdy = 1'b1;
    alloc_valid = av; alloc_reg_dest = d;
    cdb_valid = cv; cdb_tag = t; cdb_data = dat;
    cdb_mispredict = mp; cdb_target = tg;
    cyc();
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 4'd0, 32'h0);
  endtask

  task automatic do_reset(input bit first = 1'b0);
    rst = 1'b1; rdy = 1'b1;
    alloc_valid = 0; alloc_reg_dest = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; cdb_mispredict = 0; cdb_target = 0;
    cyc(!first);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    q1_tag = 4'd3;
    q2_tag = 4'd0;
    do_reset(1'b1);

    // Reset state, then idle.
    check("rst_commit_valid", 32'(commit_valid), 32'd0);
    check("rst_commit_data", commit_data, 32'd0);
    check("rst_commit_tag", 32'(commit_tag), 32'd0);
    check("rst_commit_dest", 32'(commit_reg_dest), 32'd0);
    check("rst_clear", 32'(clear), 32'd0);
    check("rst_clear_pc", clear_pc, 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    for (int i = 0; i < 5; i++) begin
      idle();
      check("idle_no_commit", 32'(commit_valid), 32'd0);
    end

    // Out-of-order completion, in-order retirement.
    drive(1, 5'd5, 0, 0, 0);
    drive(1, 5'd6, 0, 0, 0);
    drive(1, 5'd7, 0, 0, 0);
    drive(0, 0, 1, 4'd1, 32'h22);
    check("ooo_wait1", 32'(commit_valid), 32'd0);
    drive(0, 0, 1, 4'd2, 32'h33);
    check("ooo_wait2", 32'(commit_valid), 32'd0);
    drive(0, 0, 1, 4'd0, 32'h11);
    check("ooo_wait3", 32'(commit_valid), 32'd0);
    idle();
    check("ooo_c0_valid", 32'(commit_valid), 32'd1);
    check("ooo_c0_dest", 32'(commit_reg_dest), 32'd5);
    check("ooo_c0_tag", 32'(commit_tag), 32'd0);
    check("ooo_c0_data", commit_data, 32'h11);
    idle();
    check("ooo_c1_valid", 32'(commit_valid), 32'd1);
    check("ooo_c1_dest", 32'(commit_reg_dest), 32'd6);
    check("ooo_c1_data", commit_data, 32'h22);
    idle();
    check("ooo_c2_valid", 32'(commit_valid), 32'd1);
    check("ooo_c2_tag", 32'(commit_tag), 32'd2);
    check("ooo_c2_data", commit_data, 32'h33);
    idle();
    check("ooo_drained", 32'(commit_valid), 32'd0);

    // Full boundary with tail wrap, commit+allocate while full.
    do_reset();
    for (int i = 0; i < 16; i++) drive(1, 5'(i + 1), 0, 0, 0);
    check("full_set", 32'(full), 32'd1);
    check("full_tail_wrapped", 32'(alloc_tag), 32'd0);
    drive(1, 5'd9, 0, 0, 0);
    check("full_drop_tag", 32'(alloc_tag), 32'd0);
    check("full_drop_full", 32'(full), 32'd1);
    drive(0, 0, 1, 4'd0, 32'h55);
    drive(1, 5'd9, 0, 0, 0);
    check("full_commit_valid", 32'(commit_valid), 32'd1);
    check("full_commit_tag", 32'(commit_tag), 32'd0);
    check("full_after_commit", 32'(full), 32'd0);
    check("full_next_tag", 32'(alloc_tag), 32'd0);
    drive(1, 5'd10, 0, 0, 0);
    check("full_realloc_tag", 32'(alloc_tag), 32'd1);
    check("full_again", 32'(full), 32'd1);

    // Lookup with and without CDB bypass.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 5'(i + 1), 0, 0, 0);
    q1_tag = 4'd3;
    #1;
    check("lookup_unresolved", 32'(q1_ready), 32'd0);
    cdb_valid = 1; cdb_tag = 4'd3; cdb_data = 32'hABCD;
    #1;
    check("bypass_ready", 32'(q1_ready), 32'd1);
    check("bypass_data", q1_data, 32'hABCD);
    drive(0, 0, 1, 4'd3, 32'hABCD);
    idle();
    check("lookup_stored_ready", 32'(q1_ready), 32'd1);
    check("lookup_stored_data", q1_data, 32'hABCD);

    // Mispredict flush.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 5'(i + 1), 0, 0, 0);
    drive(0, 0, 1, 4'd1, 32'h77, 1'b1, 32'h100);
    drive(0, 0, 1, 4'd2, 32'h2);
    drive(0, 0, 1, 4'd0, 32'h1);
    idle();
    check("mp_c0_tag", 32'(commit_tag), 32'd0);
    check("mp_c0_valid", 32'(commit_valid), 32'd1);
    check("mp_c0_noclear", 32'(clear), 32'd0);
    idle();
    check("mp_c1_tag", 32'(commit_tag), 32'd1);
    check("mp_c1_data", commit_data, 32'h77);
    check("mp_clear", 32'(clear), 32'd1);
    check("mp_clear_pc", clear_pc, 32'h100);
    drive(1, 5'd3, 0, 0, 0);
    check("mp_clear_pulse", 32'(clear), 32'd0);
    check("mp_no_tag2", 32'(commit_valid), 32'd0);
    check("mp_alloc_dropped", 32'(alloc_tag), 32'd0);
    drive(1, 5'd3, 0, 0, 0);
    check("mp_realloc", 32'(alloc_tag), 32'd1);
    idle();
    check("mp_still_no_tag2", 32'(commit_valid), 32'd0);

    // rdy low freezes a ready head.
    do_reset();
    drive(1, 5'd4, 0, 0, 0);
    drive(0, 0, 1, 4'd0, 32'h99);
    for (int i = 0; i < 3; i++) begin
      rdy = 1'b0;
      alloc_valid = 0; cdb_valid = 0;
      cyc();
      check("frozen_no_commit", 32'(commit_valid), 32'd0);
      check("frozen_tag", 32'(alloc_tag), 32'd1);
    end
    idle();
    check("thaw_commit", 32'(commit_valid), 32'd1);
    check("thaw_data", commit_data, 32'h99);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 299) == 0);
      rdy            = ($urandom_range(0, 9) != 0);
      alloc_valid    = ($urandom_range(0, 9) < 6);
      alloc_reg_dest = 5'($urandom);
      cdb_valid      = 1'($urandom);
      if (mq.size() > 0 && $urandom_range(0, 4) != 0)
        cdb_tag = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        cdb_tag = 4'($urandom);
      cdb_data       = $urandom;
      cdb_mispredict = ($urandom_range(0, 15) == 0);
      cdb_target     = $urandom;
      q1_tag         = 4'($urandom);
      q2_tag         = (mq.size() > 0) ? mq[0].tag : 4'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
